// File: rtl/layer_sched_ctrl_pkg.sv
// Shared types and constants for the layer scheduler.
// Holds the FSM state enum and its width, the default stall and watchdog
// lengths, the counter width and a one-hot helper for layer enables.
package layer_sched_ctrl_pkg;

  localparam int unsigned STATE_W          = 3;
  localparam int unsigned CNT_W            = 32;
  localparam int unsigned LAYER_IDX_W      = 3;
  localparam int unsigned MAX_LAYERS       = 8;
  localparam int unsigned DEF_STALL_CYCLES = 1000;
  localparam int unsigned DEF_WDOG_CYCLES  = 32'd1 << 24;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_STALL = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // One-hot vector for a layer index, sized for the largest legal layer count.
  function automatic logic [MAX_LAYERS-1:0] layer_onehot(input logic [LAYER_IDX_W-1:0] idx);
    return MAX_LAYERS'(1) << idx;
  endfunction

endpackage

// File: rtl/layer_stall_timer.sv
// Loadable 32-bit up-counter with clear and terminal-count detect.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clr_i        force count to zero (highest priority)
//   load_i       load load_val_i into the count
//   load_val_i   value loaded by load_i
//   inc_i        increment the count by one
//   term_i       terminal value compared against the current count
//   tc_c         combinational: current count equals term_i
module layer_stall_timer
  import layer_sched_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             tc_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear beats load beats increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_c = (cnt_q == term_i);

endmodule

// File: rtl/layer_sched_ctrl.sv
// Sequences NUM_LAYERS layer engines one at a time with a fixed idle gap.
// A run starts when the host enables it and finishes loading the input
// buffer (falling edge of load_we); each layer runs until its own finish
// flag, then STALL_CYCLES idle cycles pass before the next layer starts.
// Optional run watchdog: define LAYER_SCHED_WDOG_EN.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   en           host run enable; low aborts the sequence
//   load_we      host input-buffer write enable
//   layer_fin    per-layer work finished (level)
//   layer_en     per-layer enable, one-hot or zero
//   cur_layer    index of the active or pending layer
//   busy         high whenever the FSM is not idle
//   done         one-cycle pulse on sequence completion
//   err          sticky watchdog error (constant 0 without the watchdog)
module layer_sched_ctrl
  import layer_sched_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LAYERS   = 5,
  parameter int unsigned STALL_CYCLES = DEF_STALL_CYCLES,
  parameter int unsigned WDOG_CYCLES  = DEF_WDOG_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   load_we,
  input  logic [NUM_LAYERS-1:0]  layer_fin,
  output logic [NUM_LAYERS-1:0]  layer_en,
  output logic [LAYER_IDX_W-1:0] cur_layer,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam logic [CNT_W-1:0]       STALL_TERM = CNT_W'(STALL_CYCLES - 1);
  localparam logic [LAYER_IDX_W-1:0] LAST_LAYER = LAYER_IDX_W'(NUM_LAYERS - 1);

  state_e                 state_q;
  logic [NUM_LAYERS-1:0]  layer_en_q;
  logic [LAYER_IDX_W-1:0] cur_layer_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   load_we_q;
  logic                   negedge_we_c;
  logic                   fin_cur_c;
  logic                   stall_tc_c;

  assign negedge_we_c = !load_we && load_we_q;

  // layer_en_q is the one-hot of cur_layer in RUN and zero elsewhere, so this
  // masks out non-current finish bits and all finish bits outside RUN.
  assign fin_cur_c = |(layer_fin & layer_en_q);

  // Stall counter: held at zero outside STALL, so it starts at 0 on entry.
  layer_stall_timer u_stall_timer (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (state_q != S_STALL),
    .load_i     (1'b0),
    .load_val_i ('0),
    .inc_i      (state_q == S_STALL),
    .term_i     (STALL_TERM),
    .tc_c       (stall_tc_c)
  );

`ifdef LAYER_SCHED_WDOG_EN
  localparam logic [CNT_W-1:0] WDOG_TERM = CNT_W'(WDOG_CYCLES - 1);

  logic err_q;
  logic wdog_tc_c;

  // Run watchdog: zero on RUN entry, counts every RUN cycle.
  layer_stall_timer u_wdog_timer (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (state_q != S_RUN),
    .load_i     (1'b0),
    .load_val_i ('0),
    .inc_i      (state_q == S_RUN),
    .term_i     (WDOG_TERM),
    .tc_c       (wdog_tc_c)
  );

  assign err = err_q;
`else
  // Keeps WDOG_CYCLES referenced in builds without the watchdog.
  logic unused_wdog;
  assign unused_wdog = ^CNT_W'(WDOG_CYCLES);
  assign err         = 1'b0;
`endif

  // Sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      layer_en_q  <= '0;
      cur_layer_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      load_we_q   <= 1'b0;
`ifdef LAYER_SCHED_WDOG_EN
      err_q       <= 1'b0;
`endif
    end else begin
      load_we_q <= load_we;
      done_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          layer_en_q <= '0;
          if (en) begin
            state_q     <= S_LOAD;
            cur_layer_q <= '0;
            busy_q      <= 1'b1;
          end
        end
        S_LOAD: begin
          if (!en) begin
            state_q     <= S_IDLE;
            cur_layer_q <= '0;
            busy_q      <= 1'b0;
          end else if (negedge_we_c) begin
            state_q    <= S_RUN;
            layer_en_q <= NUM_LAYERS'(layer_onehot(cur_layer_q));
          end
        end
        S_RUN: begin
          if (!en) begin
            state_q     <= S_IDLE;
            layer_en_q  <= '0;
            cur_layer_q <= '0;
            busy_q      <= 1'b0;
          end else if (fin_cur_c) begin
            state_q    <= S_STALL;
            layer_en_q <= '0;
          end
`ifdef LAYER_SCHED_WDOG_EN
          else if (wdog_tc_c) begin
            state_q     <= S_IDLE;
            layer_en_q  <= '0;
            cur_layer_q <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b1;
          end
`endif
        end
        S_STALL: begin
          if (!en) begin
            state_q     <= S_IDLE;
            cur_layer_q <= '0;
            busy_q      <= 1'b0;
          end else if (stall_tc_c) begin
            if (cur_layer_q == LAST_LAYER) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= S_RUN;
              cur_layer_q <= cur_layer_q + LAYER_IDX_W'(1);
              layer_en_q  <= NUM_LAYERS'(layer_onehot(cur_layer_q + LAYER_IDX_W'(1)));
            end
          end
        end
        S_DONE: begin
          // en is deliberately ignored here; a new run starts from IDLE.
          state_q     <= S_IDLE;
          cur_layer_q <= '0;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q     <= S_IDLE;
          layer_en_q  <= '0;
          cur_layer_q <= '0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign layer_en  = layer_en_q;
  assign cur_layer = cur_layer_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_layer_sched_ctrl.sv
// Scoreboard bench for layer_sched_ctrl (3 layers, 4-cycle stall).
// Stimulus pushes the expected layer-start / done events; a monitor pops
// and compares them whenever the DUT raises a layer enable or done.
`timescale 1ns/1ps
module tb_layer_sched_ctrl;

  localparam int NL    = 3;
  localparam int STALL = 4;
  localparam int WDOG  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          load_we = 1'b0;
  logic [NL-1:0] layer_fin = '0;
  logic [NL-1:0] layer_en;
  logic [2:0]    cur_layer;
  logic          busy;
  logic          done;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit is_done;
    int layer;
    int gap;      // expected idle cycles before the event, -1 = don't care
  } exp_t;

  exp_t exp_q[$];

  layer_sched_ctrl #(
    .NUM_LAYERS  (NL),
    .STALL_CYCLES(STALL),
    .WDOG_CYCLES (WDOG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load_we   (load_we),
    .layer_fin (layer_fin),
    .layer_en  (layer_en),
    .cur_layer (cur_layer),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push_exp(input bit d, input int l, input int g);
    exp_t e;
    e.is_done = d;
    e.layer   = l;
    e.gap     = g;
    exp_q.push_back(e);
  endtask

  // Expected run from the rules: layers 0..NL-1 start in order, STALL idle
  // cycles between layers, and done follows STALL idle cycles after the last.
  task automatic push_full_run();
    for (int k = 0; k < NL; k++) push_exp(1'b0, k, (k == 0) ? -1 : STALL);
    push_exp(1'b1, NL - 1, STALL);
  endtask

  // Monitor: compares every observed layer start and done pulse with the queue.
  initial begin : monitor
    logic [NL-1:0] prev_en;
    bit            prev_done;
    int            zeros;
    exp_t          e;
    prev_en   = '0;
    prev_done = 1'b0;
    zeros     = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_en   = '0;
        prev_done = 1'b0;
        zeros     = 0;
        continue;
      end
      if (done) begin
        check("done_single_cycle", 32'(prev_done), 0);
        if (exp_q.size() == 0) begin
          check("done_expected", 32'(exp_q.size()), 1);
        end else begin
          e = exp_q.pop_front();
          check("done_kind", 32'(e.is_done), 1);
          check("done_gap", 32'(zeros), 32'(e.gap));
        end
      end
      if (layer_en == '0) begin
        zeros++;
      end else if (prev_en == '0) begin
        if (exp_q.size() == 0) begin
          check("layer_start_expected", 32'(exp_q.size()), 1);
        end else begin
          e = exp_q.pop_front();
          check("start_kind", 32'(e.is_done), 0);
          check("layer_en_onehot", 32'(layer_en), 32'(1) << e.layer);
          check("cur_layer", 32'(cur_layer), 32'(e.layer));
          if (e.gap >= 0) check("stall_gap", 32'(zeros), 32'(e.gap));
        end
        zeros = 0;
      end else if (layer_en != prev_en) begin
        check("layer_en_stable", 32'(layer_en), 32'(prev_en));
      end
      prev_en   = layer_en;
      prev_done = done;
    end
  end

  task automatic wait_layer(input int k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (layer_en[k]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check($sformatf("wait_layer%0d", k), 32'(layer_en), 32'(1) << k);
  endtask

  task automatic start_and_load(input int load_len);
    en = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    load_we = 1'b1;
    repeat (load_len) @(negedge clk);
    load_we = 1'b0;
  endtask

  // Drive noise on the other finish bits for d cycles, then finish layer k.
  task automatic run_layer(input int k, input int d, input int hold);
    bit            ok;
    logic [NL-1:0] noise;
    wait_layer(k, ok);
    if (!ok) return;
    for (int i = 0; i < d; i++) begin
      noise     = NL'($urandom) & ~(NL'(1) << k);
      layer_fin = noise;
      @(negedge clk);
    end
    check($sformatf("hold_layer%0d_under_noise", k), 32'(layer_en), 32'(1) << k);
    layer_fin = NL'(1) << k;
    repeat (hold) @(negedge clk);
    layer_fin = '0;
  endtask

  task automatic full_seq(input int load_len, input bit fixed_delay);
    bit seen;
    push_full_run();
    start_and_load(load_len);
    for (int k = 0; k < NL; k++)
      run_layer(k, fixed_delay ? 10 : $urandom_range(1, 12), $urandom_range(1, 3));
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("done_seen", 32'(done), 1);
    if (seen) begin
      @(negedge clk);
      check("idle_after_done_busy", 32'(busy), 0);
      check("idle_after_done_layer", 32'(cur_layer), 0);
    end
    if ($urandom_range(0, 1) == 0) en = 1'b0;
  endtask

  initial begin : stim
    bit            ok;
    logic [NL-1:0] en_acc;
    logic          done_acc;
    int            run_cyc;

    repeat (3) @(negedge clk);
    check("rst_layer_en", 32'(layer_en), 0);
    check("rst_cur_layer", 32'(cur_layer), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_without_en", 32'(busy), 0);

    // Directed run: each finish ten cycles after its enable.
    full_seq(2, 1'b1);

    for (int s = 0; s < 5; s++) full_seq($urandom_range(1, 6), 1'b0);

    // Long load: no enable may appear until the cycle after load_we falls.
    push_full_run();
    en      = 1'b1;
    load_we = 1'b1;
    en_acc  = '0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      en_acc |= layer_en;
    end
    check("no_layer_en_during_load", 32'(en_acc), 0);
    load_we = 1'b0;
    @(negedge clk);
    check("layer0_after_load_fall", 32'(layer_en), 1);
    for (int k = 0; k < NL; k++) run_layer(k, $urandom_range(1, 5), 1);
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    check("long_load_done", 32'(done), 1);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);

    // Abort during the stall after layer 0.
    push_exp(1'b0, 0, -1);
    start_and_load(2);
    run_layer(0, 3, 1);
    check("abort_in_stall", 32'(layer_en), 0);
    en = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    en_acc   = '0;
    done_acc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      en_acc   |= layer_en;
      done_acc |= done;
    end
    check("abort_no_layer_en", 32'(en_acc), 0);
    check("abort_no_done", 32'(done_acc), 0);
    check("abort_queue_drained", 32'(exp_q.size()), 0);

    // Asynchronous reset in the middle of a run.
    push_exp(1'b0, 0, -1);
    start_and_load(1);
    wait_layer(0, ok);
    @(negedge clk);
    check("run_busy_before_rst", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_layer_en", 32'(layer_en), 0);
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_cur_layer", 32'(cur_layer), 0);
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("after_rst_idle", 32'(busy), 0);

`ifdef LAYER_SCHED_WDOG_EN
    // Watchdog: layer 0 never finishes.
    push_exp(1'b0, 0, -1);
    start_and_load(2);
    wait_layer(0, ok);
    run_cyc = ok ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (layer_en[0]) run_cyc++;
      else break;
    end
    check("wdog_run_cycles", 32'(run_cyc), 32'(WDOG));
    check("wdog_err", 32'(err), 1);
    check("wdog_idle", 32'(busy), 0);
    check("wdog_layer_en", 32'(layer_en), 0);
    en = 1'b0;
    repeat (10) @(negedge clk);
    check("wdog_err_sticky", 32'(err), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("wdog_err_cleared", 32'(err), 0);
`else
    // Without the watchdog a stuck layer simply waits.
    push_exp(1'b0, 0, -1);
    start_and_load(2);
    wait_layer(0, ok);
    run_cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (layer_en[0]) run_cyc++;
    end
    check("no_wdog_still_running", 32'(run_cyc), 40);
    check("no_wdog_err", 32'(err), 0);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("no_wdog_abort_idle", 32'(busy), 0);
`endif

    repeat (3) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
